// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that shares one W-bit register between N requesters.
// Grants one requester per arbitration, writes its data, then settles for HOLD cycles.
module shared_reg_arbiter #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  input  logic                 clr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] owner,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  output logic                 busy
);

  localparam int PW      = $clog2(N);
  localparam int CW      = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int HOLD_M1 = (HOLD > 0) ? HOLD - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_HOLD} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n, owner_n, win;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    gnt_n;
  logic [W-1:0]    q_n;
  logic            q_valid_n;
  logic            found;
  logic            wr;

  // Rotating search: first set request strictly after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        win   = PW'((int'(ptr) + k) % N);
      end
    end
  end

  // A grant only commits if the owner still requests in its GRANT cycle.
  assign wr   = (state == S_GRANT) && req[owner];
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= PW'(N - 1);
      gnt     <= '0;
      owner   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      owner   <= owner_n;
      q       <= q_n;
      q_valid <= q_valid_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE:  if (found) state_n = S_GRANT;
      S_GRANT: begin
        if (HOLD > 0) begin
          state_n = S_HOLD;
          cnt_n   = CW'(HOLD_M1);
        end else begin
          state_n = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - CW'(1);
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_n     = '0;
    owner_n   = owner;
    ptr_n     = ptr;
    q_n       = q;
    q_valid_n = 1'b0;
    if (state == S_IDLE && found) begin
      gnt_n[win] = 1'b1;
      owner_n    = win;
    end
    if (wr) begin
      q_n       = wdata[int'(owner)*W +: W];
      q_valid_n = 1'b1;
      ptr_n     = owner;
    end else if (clr) begin
      q_n = '0;
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed vector table, hand sequences, then
// randomized traffic against a timeline-based reference model.
module tb_shared_reg_arbiter;
  localparam int N = 4, W = 8, HOLD = 1;

  logic           clk = 1'b0;
  logic           rst, clr;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [1:0]     owner;
  logic [W-1:0]   q;
  logic           q_valid, busy;

  int tests = 0, fails = 0;

  shared_reg_arbiter #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .clk(clk), .reset(rst), .req(req), .wdata(wdata), .clr(clr),
    .gnt(gnt), .owner(owner), .q(q), .q_valid(q_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: tracks edge numbers at which things are scheduled to happen.
  int           e = 0, sample_at = 0, grant_at = -1, busy_last = -1, m_ptr = N - 1;
  int           m_owner = 0;
  logic [N-1:0] m_gnt = '0;
  logic [W-1:0] m_q = '0;
  logic         m_qv = 1'b0, m_busy = 1'b0;

  function automatic int rr_pick(int p, logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    int w;
    if (!rst) begin
      m_ptr = N - 1; m_gnt = '0; m_owner = 0; m_q = '0; m_qv = 1'b0;
      sample_at = e + 1; grant_at = -1; busy_last = -1;
    end else begin
      m_qv = 1'b0;
      m_gnt = '0;
      if (grant_at == e && req[m_owner]) begin
        m_q = wdata[m_owner*W +: W]; m_qv = 1'b1; m_ptr = m_owner;
      end else if (clr) begin
        m_q = '0;
      end
      if (sample_at == e) begin
        w = rr_pick(m_ptr, req);
        if (w >= 0) begin
          m_gnt = N'(1) << w; m_owner = w;
          grant_at = e + 1; busy_last = e + HOLD; sample_at = e + 2 + HOLD;
        end else begin
          sample_at = e + 1;
        end
      end
    end
    m_busy = (e <= busy_last);
    e++;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(logic r, logic [N-1:0] rq, logic c, logic [N*W-1:0] wd);
    rst = r; req = rq; clr = c; wdata = wd;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic rst; logic [3:0] req; logic clr; logic [31:0] wd;
    logic [3:0] gnt; logic [1:0] own; logic [7:0] q; logic qv; logic busy;
  } vec_t;

  function automatic vec_t mk(logic r, logic [3:0] rq, logic c, logic [31:0] wd,
                              logic [3:0] g, logic [1:0] o, logic [7:0] qq, logic qv, logic b);
    vec_t v;
    v.rst = r; v.req = rq; v.clr = c; v.wd = wd;
    v.gnt = g; v.own = o; v.q = qq; v.qv = qv; v.busy = b;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    logic [N-1:0] rr;
    localparam logic [31:0] WRR = 32'h13121110;
    localparam logic [31:0] WS  = 32'h00A50000;

    // reset with all requests, then round robin 0,1,2,3,0
    tbl.push_back(mk(0, 4'hF, 0, WRR, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'hF, 0, WRR, 4'h0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h1, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 0, 8'h10, 1, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 0, 8'h10, 0, 0));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h2, 1, 8'h10, 0, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 1, 8'h11, 1, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 1, 8'h11, 0, 0));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h4, 2, 8'h11, 0, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 2, 8'h12, 1, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 2, 8'h12, 0, 0));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h8, 3, 8'h12, 0, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 3, 8'h13, 1, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 3, 8'h13, 0, 0));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h1, 0, 8'h13, 0, 1));
    tbl.push_back(mk(1, 4'hF, 0, WRR, 4'h0, 0, 8'h10, 1, 1));
    tbl.push_back(mk(1, 4'h0, 0, WRR, 4'h0, 0, 8'h10, 0, 0));
    // single requester 2 held, regrant three cycles later
    tbl.push_back(mk(1, 4'h4, 0, WS,  4'h4, 2, 8'h10, 0, 1));
    tbl.push_back(mk(1, 4'h4, 0, WS,  4'h0, 2, 8'hA5, 1, 1));
    tbl.push_back(mk(1, 4'h4, 0, WS,  4'h0, 2, 8'hA5, 0, 0));
    tbl.push_back(mk(1, 4'h4, 0, WS,  4'h4, 2, 8'hA5, 0, 1));
    tbl.push_back(mk(1, 4'h4, 0, WS,  4'h0, 2, 8'hA5, 1, 1));
    tbl.push_back(mk(1, 4'h0, 0, WS,  4'h0, 2, 8'hA5, 0, 0));
    // clear alone while idle
    tbl.push_back(mk(1, 4'h0, 1, WS,  4'h0, 2, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].clr, tbl[i].wd);
      chk($sformatf("tbl%0d_gnt", i),   gnt,     tbl[i].gnt);
      chk($sformatf("tbl%0d_owner", i), owner,   tbl[i].own);
      chk($sformatf("tbl%0d_q", i),     q,       tbl[i].q);
      chk($sformatf("tbl%0d_qv", i),    q_valid, tbl[i].qv);
      chk($sformatf("tbl%0d_busy", i),  busy,    tbl[i].busy);
    end

    // cancelled grants do not rotate priority
    step(0, 4'h0, 0, 32'h44332211);
    chk("cx_rst_busy", busy, 0);
    step(1, 4'h3, 0, 32'h44332211);
    chk("cx_gnt0", gnt, 4'h1);
    step(1, 4'h2, 0, 32'h44332211);
    chk("cx_cancel_q", q, 8'h00);
    chk("cx_cancel_qv", q_valid, 0);
    step(1, 4'h2, 0, 32'h44332211);
    step(1, 4'h2, 0, 32'h44332211);
    chk("cx_gnt1", gnt, 4'h2);
    step(1, 4'h0, 0, 32'h44332211);
    chk("cx_cancel1_qv", q_valid, 0);
    step(1, 4'hD, 0, 32'h44332211);
    step(1, 4'hD, 0, 32'h44332211);
    chk("cx_gnt0_again", gnt, 4'h1);
    step(1, 4'hD, 0, 32'h44332211);
    chk("cx_write_q", q, 8'h11);
    chk("cx_write_qv", q_valid, 1);
    step(1, 4'h0, 0, 32'h0);

    // clear colliding with a write: write wins
    step(1, 4'h4, 0, 32'h003C0000);
    chk("clr_gnt2", gnt, 4'h4);
    step(1, 4'h4, 1, 32'h003C0000);
    chk("clr_coll_q", q, 8'h3C);
    chk("clr_coll_qv", q_valid, 1);
    step(1, 4'h0, 0, 32'h0);
    step(1, 4'h0, 1, 32'h0);
    chk("clr_alone_q", q, 8'h00);
    chk("clr_alone_qv", q_valid, 0);

    // reset during HOLD
    step(1, 4'h8, 0, 32'hFF000000);
    chk("rh_gnt3", gnt, 4'h8);
    step(1, 4'h8, 0, 32'hFF000000);
    chk("rh_q", q, 8'hFF);
    step(0, 4'hA, 0, 32'hFF000000);
    chk("rh_rst_q", q, 8'h00);
    chk("rh_rst_busy", busy, 0);
    chk("rh_rst_gnt", gnt, 4'h0);
    chk("rh_rst_owner", owner, 0);
    step(1, 4'hA, 0, 32'hFF000000);
    chk("rh_gnt1", gnt, 4'h2);
    chk("rh_owner1", owner, 1);

    // randomized traffic against the model
    rr = 4'hA;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 3) == 0) rr[b] = ~rr[b];
      step($urandom_range(0, 63) != 0, rr, $urandom_range(0, 7) == 0, N*W'($urandom));
      chk($sformatf("rnd%0d_gnt", c),   gnt,     m_gnt);
      chk($sformatf("rnd%0d_owner", c), owner,   m_owner);
      chk($sformatf("rnd%0d_q", c),     q,       m_q);
      chk($sformatf("rnd%0d_qv", c),    q_valid, m_qv);
      chk($sformatf("rnd%0d_busy", c),  busy,    m_busy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin arbiter and sequencer that shares a single W-bit storage register, built from reset-to-zero flip-flops, between N requesters. It picks one requester at a time and issues a one-cycle grant. It writes that requester's data into the register, then holds the register busy for a programmable settle period before arbitrating again. It sits between the requesting datapath units and the shared register in the week-6 storage path.

## Interface
Parameters:
- N, 4, number of requesters (N ≥ 2)
- W, 8, data width of the shared register
- HOLD, 1, settle cycles after each write (HOLD ≥ 0)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk; dominates every other input
- req  input  N  request per requester; level, must be held until granted
- wdata  input  N*W  write data; requester i occupies bits [i*W +: W]
- clr  input  1  synchronous clear of the register contents
- gnt  output  N  one-hot grant; high exactly one cycle per grant; all-zero otherwise
- owner  output  $clog2(N)  index of the last granted requester
- q  output  W  shared register contents
- q_valid  output  1  one-cycle pulse; high in the cycle q first shows newly written data
- busy  output  1  high whenever state ≠ IDLE

## Operation
- States are IDLE, GRANT and HOLD. All outputs are registered, and there are no combinational paths from inputs to outputs.
- IDLE:
  - If req ≠ 0, the winner is the first set bit searching upward from (ptr+1) mod N, wrapping past N-1 to 0.
  - Load gnt with the one-hot winner, set owner to the winner index, and go to GRANT.
  - If req = 0, stay in IDLE with gnt = 0.
- GRANT (exactly one cycle, gnt asserted):
  - If req[owner] is still high: q ← wdata[owner], q_valid ← 1 next cycle, ptr ← owner.
  - If req[owner] has dropped, the write is cancelled: q is unchanged, no q_valid pulse, and ptr is unchanged.
  - Next state is HOLD if HOLD > 0, otherwise IDLE.
  - gnt clears on exit.
- HOLD: count HOLD cycles down to zero, then go to IDLE. Requests are ignored while in HOLD.
- clr:
  - When clr is high with no write in the same cycle, q ← 0 next cycle and no q_valid pulse.
  - A GRANT write in the same cycle takes priority over clr.
  - clr does not affect state, ptr, gnt or owner.
- Reset (reset = 0 at a rising edge), including mid-GRANT or mid-HOLD:
  - state = IDLE, gnt = 0, owner = 0, q = 0, q_valid = 0, busy = 0.
  - ptr = N-1, so requester 0 has highest priority first.
  - Any in-flight write is lost.
- Fairness: after requester i is granted and writes, i has the lowest priority in the next arbitration. A cancelled grant does not rotate priority.

## Timing
- Request sampled in IDLE at edge t:
  - gnt and owner valid during cycle t+1 (state GRANT).
  - q updated and q_valid = 1 during cycle t+2.
- busy is high from cycle t+1 through the last HOLD cycle, t+1+HOLD.
- Back in IDLE at cycle t+2+HOLD; the next earliest grant is at t+3+HOLD.
- Grant period under continuous requests is HOLD+2 cycles, i.e. 3 cycles for HOLD = 1 and 2 cycles for HOLD = 0.
- Simultaneous requests are resolved purely by ptr, with one winner per arbitration.
- Requests arriving during GRANT or HOLD wait until IDLE and are not lost as long as they remain asserted.

## Test plan
- Reset values: hold reset = 0 for 2 cycles with req = 4'b1111, then release. Expect all outputs 0 during reset, ptr = 3, and a first grant of gnt = 4'b0001 one cycle after release.
- Single requester: req = 4'b0100 held, wdata[2] = 8'hA5, HOLD = 1.
  - Expect gnt = 4'b0100 at t+1, q = 8'hA5 with q_valid = 1 at t+2, busy through t+2.
  - Expect the next gnt = 4'b0100 at t+4.
- Round-robin: req = 4'b1111 held, with each wdata[i] = 8'h10+i. Expect the grant sequence 0,1,2,3,0 and q the sequence 10,11,12,13,10, one grant every 3 cycles.
- Cancelled grant: req = 4'b0011, drop req[0] during its GRANT cycle. Expect q unchanged and no q_valid; the next grant goes to requester 1, and a later re-request of 0 still has priority over 2 and 3.
- Clear collision:
  - Assert clr together with a GRANT write of 8'h3C: expect q = 8'h3C.
  - Assert clr alone in IDLE: expect q = 8'h00 next cycle and q_valid = 0.
- Reset mid-operation: pull reset low during HOLD after writing 8'hFF. Expect q = 0, busy = 0, ptr = 3 next cycle, and with req = 4'b1010 the next grant goes to requester 1.
